bus_arbiter_nxm: RTL and testbench

//  Parametrised N-master x M-slave serial-bus arbiter, successor to the fixed 2x3 arbiter.

---
 rtl/bus_arbiter_nxm.sv | 265 ++++++++++++++++++++++++++
 tb/tb_bus_arbiter_nxm.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_nxm.sv
//==============================================================================
// bus_arbiter_nxm : round-robin N-master x M-slave serial-bus arbiter with one
//                   parked split transaction.       Rev 1.0
//==============================================================================
`default_nettype none

module bus_arbiter_nxm #(
    parameter int NUM_MASTERS   = 2,
    parameter int NUM_SLAVES    = 3,
    parameter int ADDR_BITS     = 2,
    parameter int SPLIT_TIMEOUT = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] m_request,
    input  logic [NUM_MASTERS-1:0] m_address_valid,
    input  logic [NUM_MASTERS-1:0] m_valid,
    input  logic [NUM_MASTERS-1:0] m_address,
    input  logic [NUM_MASTERS-1:0] m_data,
    input  logic [NUM_MASTERS-1:0] m_write_en,
    input  logic [NUM_SLAVES-1:0]  s_ready,
    input  logic [NUM_SLAVES-1:0]  s_data_in,
    input  logic [NUM_SLAVES-1:0]  s_valid_out,
    output logic [NUM_MASTERS-1:0] m_ready,
    output logic [NUM_MASTERS-1:0] m_data_out,
    output logic [NUM_MASTERS-1:0] m_valid_in,
    output logic [NUM_MASTERS-1:0] m_available,
    output logic [NUM_SLAVES-1:0]  s_address,
    output logic [NUM_SLAVES-1:0]  s_data,
    output logic [NUM_SLAVES-1:0]  s_write_en,
    output logic [NUM_SLAVES-1:0]  s_valid,
    output logic [NUM_SLAVES-1:0]  bus_ready_s,
    output logic [NUM_MASTERS-1:0] grant,
    output logic                   decode_err,
    output logic [2:0]             state
);

    localparam int MW = $clog2(NUM_MASTERS);
    localparam int MP = 1 << MW;
    localparam int SP = 1 << ADDR_BITS;
    localparam int CW = $clog2(SPLIT_TIMEOUT + 1);
    localparam int BW = $clog2(ADDR_BITS + 1);
    localparam logic [MW-1:0]        C_LAST_M   = MW'(NUM_MASTERS - 1);
    localparam logic [ADDR_BITS:0]   C_NS_LIMIT = (ADDR_BITS + 1)'(NUM_SLAVES);
    localparam logic [CW-1:0]        C_TO_MAX   = CW'(SPLIT_TIMEOUT);
    localparam logic [BW-1:0]        C_LAST_BIT = BW'(ADDR_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_ADDR = 3'd1,
        S_ADDR      = 3'd2,
        S_CONNECT   = 3'd3,
        S_BUSY      = 3'd4,
        S_SPLIT     = 3'd5,
        S_RESUME    = 3'd6
    } state_t;

    state_t               state_q;
    logic [MW-1:0]        owner_q;
    logic                 owner_valid_q;
    logic [ADDR_BITS-1:0] slave_q;
    logic                 connected_q;
    logic                 parked_valid_q;
    logic [MW-1:0]        parked_m_q;
    logic [ADDR_BITS-1:0] parked_s_q;
    logic [MW-1:0]        rr_ptr_q;
    logic [ADDR_BITS-1:0] addr_buf_q;
    logic [BW-1:0]        bit_cnt_q;
    logic [CW-1:0]        busy_cnt_q;
    logic                 decode_err_q;

    // Inputs padded to power-of-two width so register-indexed selects stay in range.
    logic [MP-1:0] w_req_x, w_av_x, w_mv_x, w_ma_x, w_md_x, w_mwe_x;
    logic [SP-1:0] w_srdy_x, w_sdi_x, w_svo_x;

    assign w_req_x  = MP'(m_request);
    assign w_av_x   = MP'(m_address_valid);
    assign w_mv_x   = MP'(m_valid);
    assign w_ma_x   = MP'(m_address);
    assign w_md_x   = MP'(m_data);
    assign w_mwe_x  = MP'(m_write_en);
    assign w_srdy_x = SP'(s_ready);
    assign w_sdi_x  = SP'(s_data_in);
    assign w_svo_x  = SP'(s_valid_out);

    function automatic logic [MW-1:0] next_m(input logic [MW-1:0] idx);
        return (idx == C_LAST_M) ? '0 : idx + MW'(1);
    endfunction

    logic [MP-1:0] w_cand;
    logic [MP-1:0] w_owner_mask;
    logic          w_other_req;
    logic          w_rr_found;
    logic [MW-1:0] w_rr_pick;
    logic [MW-1:0] w_rr_idx;
    logic          w_sp_found;
    logic [MW-1:0] w_sp_pick;
    logic [MW-1:0] w_sp_idx;
    logic          w_fwd_valid;
    logic          w_addr_err;

    assign w_cand       = w_req_x & w_av_x;
    assign w_owner_mask = MP'(1) << owner_q;
    assign w_other_req  = |(w_req_x & ~w_owner_mask);
    assign w_fwd_valid  = (state_q != S_WAIT_ADDR) && (state_q != S_ADDR);
    assign w_addr_err   = ({1'b0, addr_buf_q} >= C_NS_LIMIT);

    // Cyclic searches: IDLE starts at rr_ptr, SPLIT starts just after the owner.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_pick  = '0;
        w_rr_idx   = rr_ptr_q;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!w_rr_found && w_cand[w_rr_idx]) begin
                w_rr_found = 1'b1;
                w_rr_pick  = w_rr_idx;
            end
            w_rr_idx = next_m(w_rr_idx);
        end
        w_sp_found = 1'b0;
        w_sp_pick  = '0;
        w_sp_idx   = next_m(owner_q);
        for (int k = 0; k < NUM_MASTERS - 1; k++) begin
            if (!w_sp_found && w_req_x[w_sp_idx] && (w_sp_idx != owner_q)) begin
                w_sp_found = 1'b1;
                w_sp_pick  = w_sp_idx;
            end
            w_sp_idx = next_m(w_sp_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            owner_q        <= '0;
            owner_valid_q  <= 1'b0;
            slave_q        <= '0;
            connected_q    <= 1'b0;
            parked_valid_q <= 1'b0;
            parked_m_q     <= '0;
            parked_s_q     <= '0;
            rr_ptr_q       <= '0;
            addr_buf_q     <= '0;
            bit_cnt_q      <= '0;
            busy_cnt_q     <= '0;
            decode_err_q   <= 1'b0;
        end else begin
            decode_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (parked_valid_q) begin
                        state_q <= S_RESUME;
                    end else if (w_rr_found) begin
                        owner_q       <= w_rr_pick;
                        owner_valid_q <= 1'b1;
                        state_q       <= S_WAIT_ADDR;
                    end
                end
                S_WAIT_ADDR: begin
                    if (w_mv_x[owner_q]) begin
                        addr_buf_q <= '0;
                        bit_cnt_q  <= '0;
                        state_q    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (w_mv_x[owner_q]) begin
                        addr_buf_q <= (addr_buf_q << 1) | ADDR_BITS'(w_ma_x[owner_q]);
                        bit_cnt_q  <= bit_cnt_q + BW'(1);
                        if (bit_cnt_q == C_LAST_BIT) begin
                            state_q <= S_CONNECT;
                        end
                    end
                end
                S_CONNECT: begin
                    if (w_addr_err) begin
                        decode_err_q  <= 1'b1;
                        owner_valid_q <= 1'b0;
                        owner_q       <= '0;
                        state_q       <= S_IDLE;
                    end else if (w_srdy_x[addr_buf_q]) begin
                        slave_q     <= addr_buf_q;
                        connected_q <= 1'b1;
                        busy_cnt_q  <= '0;
                        state_q     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (!w_req_x[owner_q]) begin
                        connected_q   <= 1'b0;
                        owner_valid_q <= 1'b0;
                        rr_ptr_q      <= next_m(owner_q);
                        busy_cnt_q    <= '0;
                        state_q       <= parked_valid_q ? S_RESUME : S_IDLE;
                    end else if ((busy_cnt_q >= C_TO_MAX) && w_other_req && !parked_valid_q) begin
                        connected_q <= 1'b0;
                        busy_cnt_q  <= '0;
                        state_q     <= S_SPLIT;
                    end else if (w_av_x[owner_q]) begin
                        connected_q <= 1'b0;
                        busy_cnt_q  <= '0;
                        state_q     <= S_WAIT_ADDR;
                    end else if (w_srdy_x[slave_q]) begin
                        busy_cnt_q <= '0;
                    end else if (busy_cnt_q != C_TO_MAX) begin
                        busy_cnt_q <= busy_cnt_q + CW'(1);
                    end
                end
                S_SPLIT: begin
                    parked_valid_q <= 1'b1;
                    parked_m_q     <= owner_q;
                    parked_s_q     <= slave_q;
                    // The waiting master may have withdrawn; fall back to resuming.
                    if (w_sp_found) begin
                        owner_q <= w_sp_pick;
                        state_q <= S_WAIT_ADDR;
                    end else begin
                        owner_valid_q <= 1'b0;
                        state_q       <= S_RESUME;
                    end
                end
                S_RESUME: begin
                    parked_valid_q <= 1'b0;
                    if (w_req_x[parked_m_q]) begin
                        owner_q       <= parked_m_q;
                        owner_valid_q <= 1'b1;
                        addr_buf_q    <= parked_s_q;
                        state_q       <= S_CONNECT;
                    end else begin
                        owner_valid_q <= 1'b0;
                        state_q       <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign decode_err = decode_err_q;
    assign state      = state_q;

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_master
        logic w_own;
        assign w_own          = (owner_q == MW'(i));
        assign m_ready[i]     = connected_q && w_own && w_srdy_x[slave_q];
        assign m_data_out[i]  = connected_q && w_own && w_sdi_x[slave_q];
        assign m_valid_in[i]  = connected_q && w_own && w_svo_x[slave_q];
        assign grant[i]       = owner_valid_q && w_own;
        assign m_available[i] = (!owner_valid_q || w_own) &&
                                !(parked_valid_q && (parked_m_q == MW'(i)));
    end

    for (genvar j = 0; j < NUM_SLAVES; j++) begin : g_slave
        logic w_sel;
        assign w_sel          = connected_q && (slave_q == ADDR_BITS'(j));
        assign s_address[j]   = w_sel && w_ma_x[owner_q];
        assign s_data[j]      = w_sel && w_md_x[owner_q];
        assign s_write_en[j]  = w_sel && w_mwe_x[owner_q];
        assign s_valid[j]     = w_sel && w_mv_x[owner_q] && w_fwd_valid;
        assign bus_ready_s[j] = !(connected_q && (slave_q != ADDR_BITS'(j)));
    end

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter_nxm.sv
//==============================================================================
// tb_bus_arbiter_nxm : scoreboard bench for bus_arbiter_nxm (random + split/reset scenarios)
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_bus_arbiter_nxm;

    localparam int NM = 2;
    localparam int NS = 3;
    localparam int AB = 2;
    localparam int TO = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NM-1:0] m_request = '0, m_address_valid = '0, m_valid = '0;
    logic [NM-1:0] m_address = '0, m_data = '0, m_write_en = '0;
    logic [NS-1:0] s_ready = '0, s_data_in = '0, s_valid_out = '0;
    logic [NM-1:0] m_ready, m_data_out, m_valid_in, m_available, grant;
    logic [NS-1:0] s_address, s_data, s_write_en, s_valid, bus_ready_s;
    logic          decode_err;
    logic [2:0]    state;

    bus_arbiter_nxm #(
        .NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_BITS(AB), .SPLIT_TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .m_request(m_request), .m_address_valid(m_address_valid), .m_valid(m_valid),
        .m_address(m_address), .m_data(m_data), .m_write_en(m_write_en),
        .s_ready(s_ready), .s_data_in(s_data_in), .s_valid_out(s_valid_out),
        .m_ready(m_ready), .m_data_out(m_data_out), .m_valid_in(m_valid_in),
        .m_available(m_available), .s_address(s_address), .s_data(s_data),
        .s_write_en(s_write_en), .s_valid(s_valid), .bus_ready_s(bus_ready_s),
        .grant(grant), .decode_err(decode_err), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct { bit err; int m; int s; } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;
    int rr = 0;
    int cur_m = 0;
    int cur_s = 0;
    bit prev_conn = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [NM-1:0] reqset);
        for (int k = 0; k < NM; k++) begin
            int idx;
            idx = (rr + k) % NM;
            if (reqset[idx]) return idx;
        end
        return 0;
    endfunction

    task automatic expect_item(input bit err, input int m, input int s);
        exp_t e;
        e.err = err; e.m = m; e.s = s;
        q.push_back(e);
    endtask

    task automatic wait_grant(input logic [NM-1:0] g, input string name);
        int t = 0;
        while (grant !== g && t < 60) begin tick(); t++; end
        check(name, grant, g);
    endtask

    task automatic wait_conn(input string name);
        int t = 0;
        while (&bus_ready_s && t < 60) begin tick(); t++; end
        check(name, !(&bus_ready_s), 1);
    endtask

    task automatic send_addr(input int m, input int addr);
        m_valid = NM'(1) << m; m_address = '0;
        tick();
        for (int b = AB - 1; b >= 0; b--) begin
            if ($urandom_range(0, 2) == 0) begin m_valid = '0; tick(); end
            m_valid   = NM'(1) << m;
            m_address = addr[b] ? (NM'(1) << m) : '0;
            tick();
        end
        m_valid = '0; m_address = '0;
    endtask

    task automatic clear_bus();
        m_valid = '0; m_address = '0; m_data = '0; m_write_en = '0;
        s_ready = '0; s_data_in = '0; s_valid_out = '0;
    endtask

    task automatic txn(input logic [NM-1:0] reqset, input int addr);
        int w;
        w = pick(reqset);
        expect_item(addr >= NS, w, addr);
        s_ready = '0;
        m_request = reqset; m_address_valid = reqset;
        wait_grant(NM'(1) << w, "rr_grant");
        m_address_valid = '0; m_request = NM'(1) << w;
        send_addr(w, addr);
        if (addr >= NS) begin
            m_request = '0;
            repeat (4) tick();
        end else begin
            repeat ($urandom_range(0, 3)) tick();
            s_ready = NS'($urandom) | (NS'(1) << addr);
            wait_conn("connect");
            repeat ($urandom_range(3, 8)) begin
                m_data = NM'($urandom); m_address = NM'($urandom);
                m_write_en = NM'($urandom); m_valid = NM'($urandom);
                s_ready = NS'($urandom); s_data_in = NS'($urandom); s_valid_out = NS'($urandom);
                tick();
            end
            m_request = '0;
            rr = (w + 1) % NM;
            tick();
            clear_bus();
            repeat (2) tick();
        end
    endtask

    // M0 connects to S1, stalls; M1 takes the bus via split and connects to S0.
    task automatic split_setup();
        expect_item(1'b0, 0, 1);
        s_ready = 3'b010;
        m_request = 2'b01; m_address_valid = 2'b01;
        wait_grant(2'b01, "split_m0_grant");
        m_address_valid = '0;
        send_addr(0, 1);
        wait_conn("split_m0_connect");
        s_ready = '0;
        m_request = 2'b11;
        expect_item(1'b0, 1, 0);
        wait_grant(2'b10, "split_m1_grant");
        check("parked_avail", m_available, 2'b10);
        send_addr(1, 0);
        s_ready = 3'b001;
        wait_conn("split_m1_connect");
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_state"}, state, 0);
        check({name, "_grant"}, grant, 0);
        check({name, "_avail"}, m_available, 2'b11);
        check({name, "_busready"}, bus_ready_s, 3'b111);
        check({name, "_decode"}, decode_err, 0);
        check({name, "_routed"}, {s_address, s_data, s_write_en, s_valid,
                                  m_ready, m_data_out, m_valid_in}, 0);
    endtask

    // Monitor: pops an expectation on each new connection or decode error.
    logic [17:0] act_route, exp_route;
    logic [NS-1:0] sm;
    logic [NM-1:0] mm;
    always @(negedge clk) begin
        if (reset) begin
            prev_conn = 1'b0;
        end else begin
            bit conn;
            conn = !(&bus_ready_s);
            check("grant_onehot", $onehot0(grant), 1);
            if (decode_err) begin
                if (q.size() == 0) check("decode_unexpected", 1, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    check("decode_kind", e.err, 1);
                    check("decode_grant", grant, 0);
                    check("decode_state", state, 0);
                end
            end
            if (conn && !prev_conn) begin
                if (q.size() == 0) check("connect_unexpected", 1, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    check("connect_kind", e.err, 0);
                    check("connect_grant", grant, NM'(1) << e.m);
                    check("connect_slave", bus_ready_s, NS'(1) << e.s);
                    cur_m = e.m;
                    cur_s = e.s;
                end
            end
            act_route = {s_address, s_data, s_write_en, s_valid, m_ready, m_data_out, m_valid_in};
            if (conn) begin
                sm = NS'(1) << cur_s;
                mm = NM'(1) << cur_m;
                exp_route = {m_address[cur_m] ? sm : '0, m_data[cur_m] ? sm : '0,
                             m_write_en[cur_m] ? sm : '0, m_valid[cur_m] ? sm : '0,
                             s_ready[cur_s] ? mm : '0, s_data_in[cur_s] ? mm : '0,
                             s_valid_out[cur_s] ? mm : '0};
                check("route", act_route, exp_route);
            end else begin
                check("route_idle", act_route, 0);
            end
            prev_conn = conn;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        txn(2'b01, 2);
        txn(2'b11, 1);
        txn(2'b11, 0);
        txn(2'b11, 2);
        txn(2'b01, 3);
        for (int r = 0; r < 30; r++) begin
            txn(NM'($urandom_range(1, 3)), int'($urandom_range(0, 3)));
        end

        split_setup();
        s_ready = '0;
        repeat (2 * TO) tick();
        check("no_second_split_state", state, 4);
        check("no_second_split_grant", grant, 2'b10);
        check("parked_avail_busy", m_available, 2'b10);
        expect_item(1'b0, 0, 1);
        m_request = 2'b01;
        rr = 0;
        repeat (3) tick();
        s_ready = 3'b010;
        wait_conn("resume_connect");
        check("resume_avail", m_available, 2'b01);
        tick();
        m_request = '0;
        rr = 1;
        tick();
        clear_bus();
        repeat (2) tick();

        split_setup();
        s_ready = '0;
        m_data = 2'b11; m_valid = 2'b11;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check_reset_outputs("midreset");
        m_request = '0;
        clear_bus();
        tick();
        reset = 1'b0;
        rr = 0;
        tick();
        txn(2'b11, 1);

        repeat (5) tick();
        check("scoreboard_drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
